// File: rtl/pe_pkg.sv
// Shared defaults and derived widths for the convolution processing element.
package pe_pkg;

  localparam int DEF_KSIZE    = 5;
  localparam int DEF_PIC_W    = 16;
  localparam int DEF_WEIGHT_W = 16;
  localparam int DEF_RESULT_W = 37;

  localparam int N      = DEF_KSIZE * DEF_KSIZE;
  localparam int CNT_W  = $clog2(N);
  localparam int PROD_W = DEF_PIC_W + DEF_WEIGHT_W;

  // Narrowest accumulator that cannot overflow over a full window.
  function automatic int min_result_w(input int pic_w, input int weight_w, input int ksize);
    return pic_w + weight_w + $clog2(ksize * ksize);
  endfunction

endpackage

// File: rtl/pe_mult.sv
// Combinational unsigned multiplier; a drop-in point for a DSP or pipelined multiplier.
module pe_mult #(
  parameter int PIC_W    = 16,
  parameter int WEIGHT_W = 16
) (
  input  logic [PIC_W-1:0]          a,
  input  logic [WEIGHT_W-1:0]       b,
  output logic [PIC_W+WEIGHT_W-1:0] product
);

  // Full-width product, no truncation.
  always_comb begin
    product = (PIC_W + WEIGHT_W)'(a) * (PIC_W + WEIGHT_W)'(b);
  end

endmodule

// File: rtl/pe_conv_mac.sv
// Convolution MAC: sums KSIZE*KSIZE consecutive pixel*weight products per window
// and pulses valid for one cycle with the registered window sum.
module pe_conv_mac
  import pe_pkg::*;
#(
  parameter int KSIZE    = DEF_KSIZE,
  parameter int PIC_W    = DEF_PIC_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int RESULT_W = DEF_RESULT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIC_W-1:0]    picDat,
  input  logic [WEIGHT_W-1:0] weightDat,
  output logic [RESULT_W-1:0] result,
  output logic                valid
);

  localparam int WIN_N   = KSIZE * KSIZE;
  localparam int WCNT_W  = $clog2(WIN_N);
  localparam int WPROD_W = PIC_W + WEIGHT_W;

  if (RESULT_W < min_result_w(PIC_W, WEIGHT_W, KSIZE)) begin : g_width_check
    $error("pe_conv_mac: RESULT_W too narrow for a full window");
  end

  logic [WCNT_W-1:0]   cnt_r;
  logic [RESULT_W-1:0] acc_r;
  logic [WPROD_W-1:0]  prod_s;
  logic [RESULT_W-1:0] sum_s;
  logic                last_s;

  pe_mult #(
    .PIC_W    (PIC_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_mult (
    .a       (picDat),
    .b       (weightDat),
    .product (prod_s)
  );

  // Running sum including this cycle's product, and end-of-window detect.
  always_comb begin
    sum_s  = acc_r + RESULT_W'(prod_s);
    last_s = (cnt_r == WCNT_W'(WIN_N - 1));
  end

  // Phase counter, accumulator and registered outputs; the next window starts with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      acc_r  <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else if (last_s) begin
      cnt_r  <= '0;
      acc_r  <= '0;
      result <= sum_s;
      valid  <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + WCNT_W'(1);
      acc_r  <= sum_s;
      result <= result;
      valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_conv_mac.sv
// Directed bench for pe_conv_mac: stimulus pushes hand-computed window sums and their
// completion cycle; an independent monitor checks every valid pulse and result holding.
module tb_pe_conv_mac;

  logic        clk;
  logic        rst_n;
  logic [15:0] picDat;
  logic [15:0] weightDat;
  logic [36:0] result;
  logic        valid;

  int          checks;
  int          errors;
  int          cyc;
  int          pulses;
  int          pushes;
  logic [36:0] last_res;
  logic [36:0] exp_val_q[$];
  int          exp_cyc_q[$];

  pe_conv_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .picDat    (picDat),
    .weightDat (weightDat),
    .result    (result),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pair at the negedge; when exp >= 0 this pair completes a window.
  task automatic send(input logic [15:0] p, input logic [15:0] w, input longint exp);
    @(negedge clk);
    picDat    = p;
    weightDat = w;
    if (exp >= 0) begin
      exp_val_q.push_back(37'(exp));
      exp_cyc_q.push_back(cyc + 1);
      pushes++;
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (result !== 37'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s result=%0h valid=%0b want result=0 valid=0", name, result, valid);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin : monitor
    logic [36:0] ev;
    int          ec;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n === 1'b1) begin
        if (valid === 1'b1) begin
          pulses++;
          checks++;
          if (exp_val_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid cycle=%0d result=%0h want no pulse", cyc, result);
          end else begin
            ev = exp_val_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (result !== ev) begin
              errors++;
              $display("FAIL window_result got %0h want %0h", result, ev);
            end
            checks++;
            if (cyc != ec) begin
              errors++;
              $display("FAIL window_timing got cycle %0d want cycle %0d", cyc, ec);
            end
            last_res = ev;
          end
        end else begin
          checks++;
          if (valid !== 1'b0 || result !== last_res) begin
            errors++;
            $display("FAIL result_hold cycle=%0d result=%0h valid=%0b want %0h valid=0",
                     cyc, result, valid, last_res);
          end
        end
      end
    end
  end

  initial begin : stimulus
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    pulses    = 0;
    pushes    = 0;
    last_res  = 37'd0;
    rst_n     = 1'b0;
    picDat    = 16'd0;
    weightDat = 16'd0;
    #2;
    check_reset("reset_initial");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Window 0: 2x2 then 24 of 1x1 -> 28.
    send(16'd2, 16'd2, -1);
    for (int i = 0; i < 23; i++) send(16'd1, 16'd1, -1);
    send(16'd1, 16'd1, 28);

    // Window 1 back-to-back: 25 of 1x1 -> 25.
    for (int i = 0; i < 24; i++) send(16'd1, 16'd1, -1);
    send(16'd1, 16'd1, 25);

    // Maximum operands: 25 * 0xFFFE0001.
    for (int i = 0; i < 24; i++) send(16'hFFFF, 16'hFFFF, -1);
    send(16'hFFFF, 16'hFFFF, 64'h18_FFCE_0019);

    // Ramp: pixels 1..25 times 2 -> 2*325 = 650.
    for (int i = 1; i < 25; i++) send(16'(i), 16'd2, -1);
    send(16'd25, 16'd2, 650);

    // Abort a window after 10 pairs of 3x3; reset clears outputs asynchronously.
    for (int i = 0; i < 10; i++) send(16'd3, 16'd3, -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    last_res = 37'd0;
    #1;
    check_reset("reset_mid_window");
    @(posedge clk);
    #1;
    check_reset("reset_held");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) send(16'd1, 16'd1, -1);
    send(16'd1, 16'd1, 25);

    // Alternating 2x2 / 1x1 starting and ending on 2x2 -> 13*4 + 12 = 64.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) send(16'd2, 16'd2, -1);
      else            send(16'd1, 16'd1, -1);
    end
    send(16'd2, 16'd2, 64);

    // Drain with zero pairs; no further pulse is expected within this span.
    for (int i = 0; i < 5; i++) send(16'd0, 16'd0, -1);
    @(posedge clk);
    #3;

    checks++;
    if (exp_val_q.size() != 0 || pulses != pushes) begin
      errors++;
      $display("FAIL pulse_count got %0d pulses (%0d pending) want %0d",
               pulses, exp_val_q.size(), pushes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
